// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//
// On-chip exhaustive sweep of a combinational N_IN-input boolean function.
// On start, every input vector 0 .. 2^N_IN-1 is driven onto the function in
// turn. Each vector is held for SETTLE cycles, then the function output is
// captured into a packed truth table and a running minterm count.
//
// Optional build macro: SWEEPER_COMPARE_EN
//   Defined   : adds the 'expected' golden-table input. Each captured bit is
//               compared to it, and the first miscompare of a sweep is flagged.
//   Undefined : no comparator; mismatch and first_err_idx are constant 0.
//
// Parameters
//   N_IN    number of function inputs (1..6); the table is 2^N_IN bits wide
//   SETTLE  cycles each vector is held before sampling (>= 1)
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   start          sweep request, honoured in IDLE only
//   f_in           output of the function under test
//   expected       golden truth table (SWEEPER_COMPARE_EN only)
//   vec_out        vector driven to the function; MSB is the first input (a)
//   busy           high while a sweep is running
//   done           one-cycle pulse when a sweep completes
//   table_out      captured truth table, bit i = f(i)
//   ones_count     number of 1 bits captured
//   mismatch       sticky miscompare flag (0 without SWEEPER_COMPARE_EN)
//   first_err_idx  vector of the first miscompare (0 without SWEEPER_COMPARE_EN)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module truth_table_sweeper #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   f_in,
`ifdef SWEEPER_COMPARE_EN
    input  logic [(1<<N_IN)-1:0]   expected,
`endif
    output logic [N_IN-1:0]        vec_out,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   table_out,
    output logic [N_IN:0]          ones_count,
    output logic                   mismatch,
    output logic [N_IN-1:0]        first_err_idx
);

    // Settle counter runs 0 .. SETTLE-1; keep it at least one bit wide.
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   settle_cnt;
    logic            accept;     // start taken this cycle
    logic            sample;     // f_in captured this cycle
    logic            last_vec;

    assign last_vec = (vec_out == {N_IN{1'b1}});

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        sample    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (settle_cnt == CW'(SETTLE - 1)) begin
                    sample = 1'b1;
                    if (last_vec) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                // start is deliberately not looked at here.
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Sweep datapath. The table is a flat register (not a RAM), so it is
    // cleared by reset along with the rest of the visible state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_out    <= '0;
            settle_cnt <= '0;
            table_out  <= '0;
            ones_count <= '0;
        end else if (accept) begin
            vec_out    <= '0;
            settle_cnt <= '0;
            table_out  <= '0;
            ones_count <= '0;
        end else if (sample) begin
            table_out[vec_out] <= f_in;
            ones_count         <= ones_count + {{N_IN{1'b0}}, f_in};
            settle_cnt         <= '0;
            // Wraps to 0 after the last vector, leaving vec_out idle at 0.
            vec_out            <= vec_out + N_IN'(1);
        end else if (busy) begin
            settle_cnt <= settle_cnt + CW'(1);
        end
    end

`ifdef SWEEPER_COMPARE_EN
    // Only the first miscompare of a sweep is recorded; later ones are ignored
    // so first_err_idx always points at the lowest failing vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch      <= 1'b0;
            first_err_idx <= '0;
        end else if (accept) begin
            mismatch      <= 1'b0;
            first_err_idx <= '0;
        end else if (sample && !mismatch && (f_in != expected[vec_out])) begin
            mismatch      <= 1'b1;
            first_err_idx <= vec_out;
        end
    end
`else
    assign mismatch      = 1'b0;
    assign first_err_idx = '0;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
`timescale 1ns/1ps

module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst;

    // DUT A: default SETTLE=1, selectable function
    logic        start_a;
    logic        f_a;
    logic [3:0]  vec_a;
    logic        busy_a, done_a;
    logic [15:0] tab_a;
    logic [4:0]  ones_a;
    logic        mm_a;
    logic [3:0]  idx_a;
    logic [15:0] exp_a;
    int          func_a;

    // DUT B: SETTLE=3, f = a (vec MSB)
    logic        start_b;
    logic        f_b;
    logic [3:0]  vec_b;
    logic        busy_b, done_b;
    logic [15:0] tab_b;
    logic [4:0]  ones_b;
    logic        mm_b;
    logic [3:0]  idx_b;
    logic [15:0] exp_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    truth_table_sweeper #(.N_IN(4), .SETTLE(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .f_in(f_a),
`ifdef SWEEPER_COMPARE_EN
        .expected(exp_a),
`endif
        .vec_out(vec_a), .busy(busy_a), .done(done_a), .table_out(tab_a),
        .ones_count(ones_a), .mismatch(mm_a), .first_err_idx(idx_a)
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .f_in(f_b),
`ifdef SWEEPER_COMPARE_EN
        .expected(exp_b),
`endif
        .vec_out(vec_b), .busy(busy_b), .done(done_b), .table_out(tab_b),
        .ones_count(ones_b), .mismatch(mm_b), .first_err_idx(idx_b)
    );

    // Function models: vec bits are {a,b,c,d}.
    // 0: b&c&d | a&~c&~d   1: const 0   2: const 1   3: a   4: func 0 with bit 12 forced 0
    always_comb begin
        logic fm;
        fm = (vec_a[2] & vec_a[1] & vec_a[0]) | (vec_a[3] & ~vec_a[1] & ~vec_a[0]);
        case (func_a)
            0:       f_a = fm;
            1:       f_a = 1'b0;
            2:       f_a = 1'b1;
            3:       f_a = vec_a[3];
            4:       f_a = fm & (vec_a != 4'd12);
            default: f_a = 1'b0;
        endcase
    end
    assign f_b = vec_b[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Pulse start on DUT A and follow the sweep to its done pulse.
    // poke >= 0 re-pulses start while vec_a == poke; poke_done re-pulses it in DONE.
    task automatic run_a(input int poke, input bit poke_done,
                         output int bcyc, output int dpulses);
        bit poked = 0;
        bcyc    = 0;
        dpulses = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 200; i++) begin
            start_a = 1'b0;
            if (busy_a) bcyc++;
            if (busy_a && poke >= 0 && !poked && vec_a == poke[3:0]) begin
                start_a = 1'b1;
                poked   = 1;
            end
            if (done_a) begin
                dpulses++;
                if (poke_done) start_a = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        start_a = 1'b0;
    endtask

    typedef struct {
        string       name;
        int          func;
        logic [15:0] exp_table;
        logic [4:0]  exp_ones;
        logic [15:0] golden;
        logic        exp_mm;
        logic [3:0]  exp_idx;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int bc, dn;

        vecs[0] = '{"minterm", 0, 16'h9180, 5'd4,  16'h9180, 1'b0, 4'd0};
        vecs[1] = '{"zero",    1, 16'h0000, 5'd0,  16'h0000, 1'b0, 4'd0};
        vecs[2] = '{"one",     2, 16'hFFFF, 5'd16, 16'hFFFF, 1'b0, 4'd0};
        vecs[3] = '{"a_only",  3, 16'hFF00, 5'd8,  16'hFF00, 1'b0, 4'd0};
        vecs[4] = '{"bit12",   4, 16'h8180, 5'd3,  16'h9180, 1'b1, 4'd12};
`ifndef SWEEPER_COMPARE_EN
        vecs[4].exp_mm  = 1'b0;
        vecs[4].exp_idx = 4'd0;
`endif

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        func_a = 0; exp_a = 16'h9180; exp_b = 16'hFF00;
        repeat (2) @(negedge clk);
        check("rst_busy",  {31'd0, busy_a}, 32'd0);
        check("rst_done",  {31'd0, done_a}, 32'd0);
        check("rst_vec",   {28'd0, vec_a},  32'd0);
        check("rst_table", {16'd0, tab_a},  32'd0);
        check("rst_ones",  {27'd0, ones_a}, 32'd0);
        check("rst_mm",    {31'd0, mm_a},   32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven single sweeps
        foreach (vecs[k]) begin
            func_a = vecs[k].func;
            exp_a  = vecs[k].golden;
            run_a(-1, 0, bc, dn);
            check({vecs[k].name, "_busy_cycles"}, bc, 32'd16);
            check({vecs[k].name, "_done_pulses"}, dn, 32'd1);
            check({vecs[k].name, "_done_single"}, {31'd0, done_a}, 32'd0);
            check({vecs[k].name, "_table"}, {16'd0, tab_a}, {16'd0, vecs[k].exp_table});
            check({vecs[k].name, "_ones"},  {27'd0, ones_a}, {27'd0, vecs[k].exp_ones});
            check({vecs[k].name, "_mismatch"}, {31'd0, mm_a}, {31'd0, vecs[k].exp_mm});
            check({vecs[k].name, "_err_idx"},  {28'd0, idx_a}, {28'd0, vecs[k].exp_idx});
            check({vecs[k].name, "_vec_idle"}, {28'd0, vec_a}, 32'd0);
        end

        // SETTLE=3 sweep: each vector held exactly 3 cycles, in order
        begin
            int prev = -1, runlen = 0, bad = 0;
            bc = 0; dn = 0;
            @(negedge clk); start_b = 1'b1;
            @(negedge clk); start_b = 1'b0;
            for (int i = 0; i < 400; i++) begin
                if (busy_b) begin
                    bc++;
                    if (prev < 0) begin
                        if (vec_b != 4'd0) bad++;
                        prev = vec_b; runlen = 1;
                    end else if (int'(vec_b) == prev) begin
                        runlen++;
                    end else begin
                        if (runlen != 3 || int'(vec_b) != prev + 1) bad++;
                        prev = vec_b; runlen = 1;
                    end
                end
                if (done_b) begin
                    dn++;
                    if (runlen != 3) bad++;
                    break;
                end
                @(negedge clk);
            end
            check("s3_busy_cycles", bc, 32'd48);
            check("s3_done_pulses", dn, 32'd1);
            check("s3_hold_errors", bad, 32'd0);
            check("s3_last_vec", prev, 32'd15);
            check("s3_table", {16'd0, tab_b}, 32'h0000FF00);
            check("s3_ones", {27'd0, ones_b}, 32'd8);
        end

        // Reset in the middle of a sweep at vec_out == 5
        func_a = 2; exp_a = 16'hFFFF;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        for (int i = 0; i < 50 && vec_a != 4'd5; i++) @(negedge clk);
        check("pre_rst_vec", {28'd0, vec_a}, 32'd5);
        check("pre_rst_ones", {27'd0, ones_a}, 32'd5);
        rst = 1'b1;
        #1;
        check("midrst_busy",  {31'd0, busy_a}, 32'd0);
        check("midrst_vec",   {28'd0, vec_a},  32'd0);
        check("midrst_table", {16'd0, tab_a},  32'd0);
        check("midrst_ones",  {27'd0, ones_a}, 32'd0);
        begin
            int seen_done = 0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (done_a) seen_done++;
            end
            rst = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (done_a || busy_a) seen_done++;
            end
            check("midrst_no_done", seen_done, 32'd0);
        end
        func_a = 0; exp_a = 16'h9180;
        run_a(-1, 0, bc, dn);
        check("post_rst_table", {16'd0, tab_a}, 32'h00009180);
        check("post_rst_ones",  {27'd0, ones_a}, 32'd4);

        // start re-pulsed during RUN (vec 8) and during DONE: both ignored
        run_a(8, 1, bc, dn);
        check("poke_busy_cycles", bc, 32'd16);
        check("poke_done_pulses", dn, 32'd1);
        check("poke_done_ignored", {31'd0, busy_a}, 32'd0);
        @(negedge clk);
        check("poke_still_idle", {31'd0, busy_a}, 32'd0);
        check("poke_table", {16'd0, tab_a}, 32'h00009180);

        // start held high: back-to-back sweeps with a single idle cycle between
        start_a = 1'b1;
        dn = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_a) begin dn++; break; end
        end
        check("held_first_done", dn, 32'd1);
        @(negedge clk);
        check("held_gap_busy", {31'd0, busy_a}, 32'd0);
        check("held_gap_done", {31'd0, done_a}, 32'd0);
        @(negedge clk);
        check("held_restart_busy", {31'd0, busy_a}, 32'd1);
        start_a = 1'b0;
        dn = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_a) begin dn++; break; end
        end
        check("held_second_done", dn, 32'd1);
        check("held_second_table", {16'd0, tab_a}, 32'h00009180);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Sequencer for a combinational N-input boolean function block, for example the 4-input minterm logic. On a start request it drives every input vector from 0 to 2^N-1 onto the function under test. It waits a fixed settle time per vector, samples the function output, and builds the packed truth table plus a minterm count. Sits beside the logic block and replaces the bench-side exhaustive loop with a reusable on-chip sweep.

Parameters:
N_IN, 4, number of function inputs; the table is 2^N_IN bits wide (legal range 1..6).
SETTLE, 1, clock cycles each vector is held before sampling (legal range >= 1).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
start  input  1  sweep request; sampled in IDLE only.
f_in  input  1  output of the function under test.
vec_out  output  N_IN  input vector driven to the function; MSB maps to the first input (a).
busy  output  1  high while a sweep is in progress.
done  output  1  one-cycle pulse when the sweep completes.
table_out  output  2^N_IN  bit i = f(i); cleared when start is accepted.
ones_count  output  N_IN+1  number of 1 bits captured (minterm count).
mismatch  output  1  only with COMPARE_EN; tied 0 otherwise.
first_err_idx  output  N_IN  only with COMPARE_EN; tied 0 otherwise.
expected  input  2^N_IN  only with COMPARE_EN; golden table.

Behaviour:
- Reset (async, rst=1): state IDLE; vec_out, table_out, ones_count, busy, done, mismatch and first_err_idx are all 0. Reset mid-sweep aborts immediately; no done pulse is issued.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on the clock edge where start=1.
  - On that edge: table_out=0, ones_count=0, vec_out=0, settle counter=0, busy=1.
- RUN: vec_out holds the current index for SETTLE cycles.
  - On the SETTLE-th edge, f_in is written to table_out[vec_out] and ones_count increments by f_in.
  - On that same edge, if vec_out != 2^N_IN-1, vec_out increments and the settle counter resets.
  - If vec_out == 2^N_IN-1, the state moves to DONE and vec_out wraps to 0.
- Busy duration: exactly 2^N_IN*SETTLE cycles (16 for the defaults).
- DONE: lasts 1 cycle with done=1 and busy=0, then returns to IDLE. start is ignored in DONE.
- start while RUN or DONE is ignored; there is no restart and no queuing.
- table_out and ones_count hold their values after done until the next accepted start.
- ones_count saturation cannot occur: its width N_IN+1 holds the maximum value 2^N_IN.
- A start held continuously re-triggers a new sweep from the first IDLE cycle after DONE, so the gap between sweeps is 1 idle cycle.
- f_in is sampled synchronously; the function block must settle within SETTLE cycles.

Optional Feature:
Macro SWEEPER_COMPARE_EN.
- Defined: adds the expected port.
  - Each captured bit is compared to expected[vec_out].
  - On the first mismatch of a sweep: mismatch=1 and first_err_idx=vec_out. Both stick until the next accepted start, which clears them to 0.
  - Both are valid by the done pulse.
- Undefined: no expected port, no comparator logic; mismatch and first_err_idx are constant 0.

Test Plan:
1. f_in = b&c&d | a&~c&~d, defaults, pulse start -> busy for 16 cycles; done pulses once; table_out=16'h9180; ones_count=4.
2. f_in tied 0, then tied 1 (two sweeps) -> table_out=16'h0000 with ones_count=0, then table_out=16'hFFFF with ones_count=16.
3. SETTLE=3, f_in=a (vec_out[3]) -> busy for 48 cycles; each vec_out value is stable for 3 cycles; table_out=16'hFF00; ones_count=8.
4. Assert rst during RUN at vec_out=5 -> all outputs 0 immediately with no done; a new start afterwards yields the correct full table.
5. start pulsed again during RUN and during DONE -> ignored; start held high -> back-to-back sweeps separated by 1 IDLE cycle.
6. SWEEPER_COMPARE_EN defined, expected=16'h9180, function as test 1 but bit 12 forced to 0 -> mismatch=1, first_err_idx=12; with the correct function -> mismatch=0.
